// File: rtl/timer_pkg.sv
// Shared constants for the multimode timer: segment codes, digit positions,
// run-state encoding and small BCD helpers.
package timer_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ERR   = 7'b0011111;

    localparam int DIG_H1     = 0;
    localparam int DIG_H0     = 1;
    localparam int DIG_M1     = 2;
    localparam int DIG_M0     = 3;
    localparam int DIG_S1     = 4;
    localparam int DIG_S0     = 5;
    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {RUN, HOLD, EXPIRED} run_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

    function automatic logic [6:0] bcd2_value(input logic [3:0] tens, input logic [3:0] ones);
        return {3'b000, tens} * 7'd10 + {3'b000, ones};
    endfunction

endpackage

// File: rtl/rate_tick.sv
// Clock-enable prescaler: one-cycle tick every DIV enabled cycles.
// A clear restarts the period from zero and suppresses any tick that cycle.
module rate_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_reg;

    assign tick = en && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + W'(1);
        end
    end
endmodule

// File: rtl/multimode_timer.sv
// HH:MM:SS up/down timer with preset load, expiry flag and a 6-digit
// multiplexed 7-segment driver, all timed by enables off mclk.
module multimode_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int SEC_HZ  = 1,
    parameter int FAST_HZ = 1000,
    parameter int SCAN_HZ = 1000,
    parameter int HOURS   = 12
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        speed,
    input  logic        dir,
    input  logic        load,
    input  logic [23:0] preset,
    output logic        done,
    output logic        wrap,
    output logic [2:0]  de,
    output logic [6:0]  seg
);
    localparam logic [6:0] HOUR_MAX = 7'(HOURS - 1);

    logic       speed_reg;
    logic       count_clr, slow_tick, fast_tick, count_tick, scan_tick, blink_tick;
    logic       blink_reg;
    logic       wrap_reg, wrap_next;
    logic [2:0] de_reg;
    logic [6:0] seg_reg;
    logic [3:0] digit_reg [NUM_DIGITS];
    logic [3:0] digit_next [NUM_DIGITS];
    logic [3:0] preset_digit [NUM_DIGITS];
    logic [23:0] count_flat;
    logic       count_zero, hour_ok, min_ok, sec_ok;
    logic [6:0] hour_val;
    run_state_t state_reg, state_next;

    // Holding the prescaler in clear while disabled makes every resume a full period.
    assign count_clr  = load || !enable || (speed != speed_reg);
    assign count_tick = speed ? fast_tick : slow_tick;

    rate_tick #(.DIV(CLK_HZ / SEC_HZ)) u_slow (
        .clk(mclk), .rst(rst), .clr(count_clr), .en(enable && !speed), .tick(slow_tick));
    rate_tick #(.DIV(CLK_HZ / FAST_HZ)) u_fast (
        .clk(mclk), .rst(rst), .clr(count_clr), .en(enable && speed), .tick(fast_tick));
    rate_tick #(.DIV(CLK_HZ / SCAN_HZ)) u_scan (
        .clk(mclk), .rst(rst), .clr(1'b0), .en(1'b1), .tick(scan_tick));
    rate_tick #(.DIV(CLK_HZ / (2 * SEC_HZ))) u_blink (
        .clk(mclk), .rst(rst), .clr(1'b0), .en(1'b1), .tick(blink_tick));

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign preset_digit[gi]           = preset[23-4*gi -: 4];
            assign count_flat[23-4*gi -: 4]   = digit_reg[gi];
        end
    endgenerate

    assign count_zero = (count_flat == 24'h0);
    assign hour_val   = bcd2_value(digit_reg[DIG_H1], digit_reg[DIG_H0]);
    assign hour_ok    = (preset_digit[DIG_H1] <= 4'd9) && (preset_digit[DIG_H0] <= 4'd9) &&
                        (bcd2_value(preset_digit[DIG_H1], preset_digit[DIG_H0]) <= HOUR_MAX);
    assign min_ok     = (preset_digit[DIG_M1] <= 4'd5) && (preset_digit[DIG_M0] <= 4'd9);
    assign sec_ok     = (preset_digit[DIG_S1] <= 4'd5) && (preset_digit[DIG_S0] <= 4'd9);

    always_comb begin
        digit_next = digit_reg;
        wrap_next  = 1'b0;
        if (load) begin
            digit_next[DIG_H1] = hour_ok ? preset_digit[DIG_H1] : 4'd0;
            digit_next[DIG_H0] = hour_ok ? preset_digit[DIG_H0] : 4'd0;
            digit_next[DIG_M1] = min_ok  ? preset_digit[DIG_M1] : 4'd0;
            digit_next[DIG_M0] = min_ok  ? preset_digit[DIG_M0] : 4'd0;
            digit_next[DIG_S1] = sec_ok  ? preset_digit[DIG_S1] : 4'd0;
            digit_next[DIG_S0] = sec_ok  ? preset_digit[DIG_S0] : 4'd0;
        end else if (count_tick && !dir) begin
            if (digit_reg[DIG_S0] != 4'd9) digit_next[DIG_S0] = digit_reg[DIG_S0] + 4'd1;
            else begin
                digit_next[DIG_S0] = 4'd0;
                if (digit_reg[DIG_S1] != 4'd5) digit_next[DIG_S1] = digit_reg[DIG_S1] + 4'd1;
                else begin
                    digit_next[DIG_S1] = 4'd0;
                    if (digit_reg[DIG_M0] != 4'd9) digit_next[DIG_M0] = digit_reg[DIG_M0] + 4'd1;
                    else begin
                        digit_next[DIG_M0] = 4'd0;
                        if (digit_reg[DIG_M1] != 4'd5) digit_next[DIG_M1] = digit_reg[DIG_M1] + 4'd1;
                        else begin
                            digit_next[DIG_M1] = 4'd0;
                            if (hour_val == HOUR_MAX) begin
                                digit_next[DIG_H1] = 4'd0;
                                digit_next[DIG_H0] = 4'd0;
                                wrap_next          = 1'b1;
                            end else if (digit_reg[DIG_H0] == 4'd9) begin
                                digit_next[DIG_H0] = 4'd0;
                                digit_next[DIG_H1] = digit_reg[DIG_H1] + 4'd1;
                            end else begin
                                digit_next[DIG_H0] = digit_reg[DIG_H0] + 4'd1;
                            end
                        end
                    end
                end
            end
        end else if (count_tick && dir && !count_zero) begin
            // Nonzero count guarantees the borrow chain never underflows the hours.
            if (digit_reg[DIG_S0] != 4'd0) digit_next[DIG_S0] = digit_reg[DIG_S0] - 4'd1;
            else begin
                digit_next[DIG_S0] = 4'd9;
                if (digit_reg[DIG_S1] != 4'd0) digit_next[DIG_S1] = digit_reg[DIG_S1] - 4'd1;
                else begin
                    digit_next[DIG_S1] = 4'd5;
                    if (digit_reg[DIG_M0] != 4'd0) digit_next[DIG_M0] = digit_reg[DIG_M0] - 4'd1;
                    else begin
                        digit_next[DIG_M0] = 4'd9;
                        if (digit_reg[DIG_M1] != 4'd0) digit_next[DIG_M1] = digit_reg[DIG_M1] - 4'd1;
                        else begin
                            digit_next[DIG_M1] = 4'd5;
                            if (digit_reg[DIG_H0] != 4'd0) digit_next[DIG_H0] = digit_reg[DIG_H0] - 4'd1;
                            else begin
                                digit_next[DIG_H0] = 4'd9;
                                digit_next[DIG_H1] = digit_reg[DIG_H1] - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = HOLD;
        if (dir && count_zero) state_next = EXPIRED;
        else if (enable)       state_next = RUN;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) state_reg <= HOLD;
        else     state_reg <= state_next;
    end

    assign done = (state_reg == EXPIRED);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            speed_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            blink_reg <= 1'b0;
            de_reg    <= 3'd0;
            seg_reg   <= SEG_0;
            for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= 4'd0;
        end else begin
            speed_reg <= speed;
            wrap_reg  <= wrap_next;
            digit_reg <= digit_next;
            if (blink_tick) blink_reg <= ~blink_reg;
            if (scan_tick)  de_reg <= (de_reg == 3'(DIG_S0)) ? 3'd0 : de_reg + 3'd1;
            seg_reg <= (done && blink_reg) ? SEG_BLANK : seg_encode(digit_reg[de_reg]);
        end
    end

    assign wrap = wrap_reg;
    assign de   = de_reg;
    assign seg  = seg_reg;
endmodule

// File: tb/tb_multimode_timer.sv
// Directed bench for multimode_timer: a HOURS=12 and a HOURS=24 instance share stimulus.
module tb_multimode_timer;
    logic        mclk = 1'b0;
    logic        rst, enable, speed, dir, load;
    logic [23:0] preset;
    logic        done12, wrap12, done24, wrap24;
    logic [2:0]  de12, de24;
    logic [6:0]  seg12, seg24;
    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    multimode_timer #(.CLK_HZ(100), .SEC_HZ(1), .FAST_HZ(10), .SCAN_HZ(50), .HOURS(12)) dut12 (
        .mclk(mclk), .rst(rst), .enable(enable), .speed(speed), .dir(dir), .load(load),
        .preset(preset), .done(done12), .wrap(wrap12), .de(de12), .seg(seg12));
    multimode_timer #(.CLK_HZ(100), .SEC_HZ(1), .FAST_HZ(10), .SCAN_HZ(50), .HOURS(24)) dut24 (
        .mclk(mclk), .rst(rst), .enable(enable), .speed(speed), .dir(dir), .load(load),
        .preset(preset), .done(done24), .wrap(wrap24), .de(de24), .seg(seg24));

    function automatic logic [6:0] tb_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;  4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;  4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;  4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;  4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;  4'd9: return 7'b1111011;
            default: return 7'b0011111;
        endcase
    endfunction

    function automatic logic [41:0] exp_disp(input logic [23:0] bcd);
        logic [41:0] r;
        for (int i = 0; i < 6; i++) r[41-7*i -: 7] = tb_seg(bcd[23-4*i -: 4]);
        return r;
    endfunction

    // Captures one full scan; seg seen at a sample belongs to de of the previous sample.
    task automatic read_display(output logic [41:0] d12, output logic [41:0] d24);
        int p12, p24;
        p12 = -1; p24 = -1; d12 = '0; d24 = '0;
        repeat (14) begin
            @(negedge mclk);
            if (p12 >= 0 && p12 <= 5) d12[41-7*p12 -: 7] = seg12;
            if (p24 >= 0 && p24 <= 5) d24[41-7*p24 -: 7] = seg24;
            p12 = int'(de12);
            p24 = int'(de24);
        end
    endtask

    task automatic do_load(input logic [23:0] v);
        preset = v;
        load   = 1'b1;
        @(negedge mclk);
        load   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge mclk);
        checks++; if (de12 !== 3'd0) begin errors++; $display("FAIL reset_de: got %0d expected 0", de12); end
        checks++; if (seg12 !== 7'b1111110) begin errors++; $display("FAIL reset_seg: got %b expected 1111110", seg12); end
        checks++; if (done12 !== 1'b0 || done24 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", done12, done24); end
        checks++; if (wrap12 !== 1'b0 || wrap24 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b/%b expected 0/0", wrap12, wrap24); end
        $display("reset checked");
        rst   = 1'b0;
        speed = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_count_up;
        logic [41:0] g12, g24;
        logic [23:0] exp_v [3];
        int          runs [3];
        exp_v[0] = 24'h000000; runs[0] = 9;
        exp_v[1] = 24'h000001; runs[1] = 10;
        exp_v[2] = 24'h000100; runs[2] = 590;
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            repeat (runs[i]) @(negedge mclk);
            enable = 1'b0;
            read_display(g12, g24);
            checks++; if (g12 !== exp_disp(exp_v[i])) begin errors++; $display("FAIL count_up_%0d dut12: got %h expected %h", i, g12, exp_disp(exp_v[i])); end
            checks++; if (g24 !== exp_disp(exp_v[i])) begin errors++; $display("FAIL count_up_%0d dut24: got %h expected %h", i, g24, exp_disp(exp_v[i])); end
            $display("count_up step %0d: %0d cycles, expect %h", i, runs[i], exp_v[i]);
        end
    endtask

    task automatic test_wrap;
        logic [41:0] g12, g24;
        logic [23:0] pv [2], e12 [2], e24 [2];
        logic        w12_exp [2], w24_exp [2];
        logic        ew12, ew24;
        pv[0] = 24'h115959; e12[0] = 24'h000000; e24[0] = 24'h120000; w12_exp[0] = 1'b1; w24_exp[0] = 1'b0;
        pv[1] = 24'h235959; e12[1] = 24'h010000; e24[1] = 24'h000000; w12_exp[1] = 1'b0; w24_exp[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_load(pv[i]);
            enable = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge mclk);
                ew12 = (k == 10) && w12_exp[i];
                ew24 = (k == 10) && w24_exp[i];
                checks++; if (wrap12 !== ew12) begin errors++; $display("FAIL wrap%0d_k%0d dut12: got %b expected %b", i, k, wrap12, ew12); end
                checks++; if (wrap24 !== ew24) begin errors++; $display("FAIL wrap%0d_k%0d dut24: got %b expected %b", i, k, wrap24, ew24); end
            end
            enable = 1'b0;
            read_display(g12, g24);
            checks++; if (g12 !== exp_disp(e12[i])) begin errors++; $display("FAIL wrap%0d_disp dut12: got %h expected %h", i, g12, exp_disp(e12[i])); end
            checks++; if (g24 !== exp_disp(e24[i])) begin errors++; $display("FAIL wrap%0d_disp dut24: got %h expected %h", i, g24, exp_disp(e24[i])); end
            $display("wrap case %0d: preset %h", i, pv[i]);
        end
    endtask

    task automatic test_speed_toggle;
        logic ew;
        do_load(24'h115959);
        enable = 1'b1;
        repeat (5) @(negedge mclk);
        speed = 1'b0;
        @(negedge mclk);
        speed = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge mclk);
            ew = (k == 11);
            checks++; if (wrap12 !== ew) begin errors++; $display("FAIL speed_toggle_k%0d: wrap got %b expected %b", k, wrap12, ew); end
        end
        enable = 1'b0;
        @(negedge mclk);
        $display("speed toggle: wrap expected 11 cycles after restore");
    endtask

    task automatic test_load_vs_tick;
        logic [41:0] g12, g24;
        enable = 1'b1;
        repeat (9) @(negedge mclk);
        do_load(24'h103045);
        enable = 1'b0;
        read_display(g12, g24);
        checks++; if (g12 !== exp_disp(24'h103045)) begin errors++; $display("FAIL load_vs_tick dut12: got %h expected %h", g12, exp_disp(24'h103045)); end
        checks++; if (g24 !== exp_disp(24'h103045)) begin errors++; $display("FAIL load_vs_tick dut24: got %h expected %h", g24, exp_disp(24'h103045)); end
        $display("load on tick cycle: expect 103045");
    endtask

    task automatic test_invalid_preset;
        logic [41:0] g12, g24;
        logic [23:0] pv [5], e12 [5], e24 [5];
        pv[0] = 24'h13750A; e12[0] = 24'h000000; e24[0] = 24'h130000;
        pv[1] = 24'h245959; e12[1] = 24'h005959; e24[1] = 24'h005959;
        pv[2] = 24'h120000; e12[2] = 24'h000000; e24[2] = 24'h120000;
        pv[3] = 24'h235959; e12[3] = 24'h005959; e24[3] = 24'h235959;
        pv[4] = 24'h096059; e12[4] = 24'h090059; e24[4] = 24'h090059;
        for (int i = 0; i < 5; i++) begin
            do_load(pv[i]);
            read_display(g12, g24);
            checks++; if (g12 !== exp_disp(e12[i])) begin errors++; $display("FAIL preset_%h dut12: got %h expected %h", pv[i], g12, exp_disp(e12[i])); end
            checks++; if (g24 !== exp_disp(e24[i])) begin errors++; $display("FAIL preset_%h dut24: got %h expected %h", pv[i], g24, exp_disp(e24[i])); end
            $display("preset %h: expect %h / %h", pv[i], e12[i], e24[i]);
        end
    endtask

    task automatic test_count_down;
        logic ed;
        int   blanks, bad;
        do_load(24'h000002);
        dir    = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge mclk);
            ed = (k >= 21);
            checks++; if (done12 !== ed || done24 !== ed) begin errors++; $display("FAIL down_done_k%0d: got %b/%b expected %b", k, done12, done24, ed); end
        end
        repeat (300) @(negedge mclk);
        blanks = 0; bad = 0;
        repeat (100) begin
            @(negedge mclk);
            if (seg12 === 7'b0000000) blanks++;
            else if (seg12 !== 7'b1111110) bad++;
        end
        checks++; if (blanks != 50) begin errors++; $display("FAIL blink_blanks: got %0d expected 50", blanks); end
        checks++; if (bad != 0) begin errors++; $display("FAIL frozen_zero: got %0d non-zero digits expected 0", bad); end
        checks++; if (done12 !== 1'b1) begin errors++; $display("FAIL done_held: got %b expected 1", done12); end
        $display("count down: done after 21 cycles, %0d blank samples", blanks);
    endtask

    task automatic test_done_clear;
        enable = 1'b0;
        do_load(24'h000005);
        @(negedge mclk);
        checks++; if (done12 !== 1'b0) begin errors++; $display("FAIL done_clear_load: got %b expected 0", done12); end
        do_load(24'h000000);
        @(negedge mclk);
        checks++; if (done12 !== 1'b1) begin errors++; $display("FAIL done_zero_load: got %b expected 1", done12); end
        dir = 1'b0;
        @(negedge mclk);
        checks++; if (done12 !== 1'b0) begin errors++; $display("FAIL done_clear_dir: got %b expected 0", done12); end
        $display("done clear by load and dir checked");
    endtask

    task automatic test_async_reset;
        logic [41:0] g12, g24;
        logic [2:0]  ede;
        // Phase 1: nonzero count, running; phase 2: expired.
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                dir = 1'b0; do_load(24'h103045); enable = 1'b1;
            end else begin
                dir = 1'b1; enable = 1'b0; do_load(24'h000000);
            end
            repeat (7) @(negedge mclk);
            if (ph == 1) begin
                checks++; if (done12 !== 1'b1) begin errors++; $display("FAIL pre_reset_done: got %b expected 1", done12); end
            end
            #2 rst = 1'b1;
            #1;
            checks++; if (de12 !== 3'd0) begin errors++; $display("FAIL async_de_%0d: got %0d expected 0", ph, de12); end
            checks++; if (seg12 !== 7'b1111110) begin errors++; $display("FAIL async_seg_%0d: got %b expected 1111110", ph, seg12); end
            checks++; if (done12 !== 1'b0) begin errors++; $display("FAIL async_done_%0d: got %b expected 0", ph, done12); end
            @(negedge mclk);
            dir    = 1'b0;
            enable = 1'b0;
            rst    = 1'b0;
            $display("async reset phase %0d applied", ph);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge mclk);
            ede = 3'((k / 2) % 6);
            checks++; if (de12 !== ede) begin errors++; $display("FAIL de_seq_k%0d: got %0d expected %0d", k, de12, ede); end
        end
        read_display(g12, g24);
        checks++; if (g12 !== exp_disp(24'h000000)) begin errors++; $display("FAIL post_reset_disp: got %h expected %h", g12, exp_disp(24'h000000)); end
        $display("de sequence and cleared display after reset checked");
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; speed = 1'b0; dir = 1'b0; load = 1'b0; preset = 24'h0;
        test_reset;
        test_count_up;
        test_wrap;
        test_speed_toggle;
        test_load_vs_tick;
        test_invalid_preset;
        test_count_down;
        test_done_clear;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multimode_timer.md
# multimode_timer

Parametrised HH:MM:SS timer with up/down counting, preset load, expiry detection and an integrated 6-digit multiplexed 7-segment driver. It replaces the single-mode, derived-clock timer: all timing runs off `mclk` through one-cycle clock enables, with no generated clocks. It sits between the board push-button/switch inputs (already debounced upstream) and the 7-segment digit-select/segment pins.

## Interface
- `CLK_HZ`, default 10_000_000: `mclk` frequency in Hz.
- `SEC_HZ`, default 1: count rate when `speed`=0.
- `FAST_HZ`, default 1000: count rate when `speed`=1.
- `SCAN_HZ`, default 1000: digit-scan rate.
- `HOURS`, default 12: hour modulus, legal 2..24; hours count 0..HOURS-1.
- `mclk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = run, 0 = hold count and freeze count prescaler.
- `speed`  in  1  0 = SEC_HZ, 1 = FAST_HZ.
- `dir`  in  1  0 = count up, 1 = count down.
- `load`  in  1  synchronous preset load, level-sampled each cycle.
- `preset`  in  24  BCD {h1,h0,m1,m0,s1,s0}, 4 bits each, h1 MSB.
- `done`  out  1  expired flag (down mode at 00:00:00).
- `wrap`  out  1  one-cycle pulse on up-count wrap to 00:00:00.
- `de`  out  3  digit select 0..5 = h1,h0,m1,m0,s1,s0.
- `seg`  out  7  segments {a..g}, active-high, registered.

## Operation
- Count state: six BCD digits. Reset clears all digits to 0.
- Count tick: a one-cycle enable every CLK_HZ/SEC_HZ or CLK_HZ/FAST_HZ cycles, selected by `speed`. The prescaler advances only while `enable`=1. It clears to 0 on `rst`, on `load`, and on any change of `speed`.
- Up mode: on each tick, s0 increments. Overflow carries s0 9→0, s1 5→0, m0 9→0, m1 5→0, then hours, as a two-digit BCD value. Hours at HOURS-1 go to 0. The transition (HOURS-1):59:59 → 00:00:00 pulses `wrap` for the same cycle in which the count changes.
- Down mode: on each tick, the count decrements with borrow. Going from 00:00:00 → 23/11:59:59 is forbidden. At 00:00:00 the count freezes.
- `done` = `dir`=1 and count = 00:00:00. It is registered and valid one cycle after the count reaches zero. It clears one cycle after `load` of a nonzero value or after `dir` goes to 0.
- Load: on the `load`=1 cycle, each field is checked. Hours > HOURS-1, minutes > 59, seconds > 59, or any digit > 9 makes that field load as 00. Valid fields load as given. `load` has priority over a tick in the same cycle; that tick is dropped.
- States: RUN (`enable`=1, not done), HOLD (`enable`=0), EXPIRED (`done`=1). EXPIRED is left only by `load`, by `dir`→0, or by `rst`. `rst` mid-count returns to 00:00:00 immediately, independent of `mclk`.
- Display: `de` advances 0→5→0 on each scan tick. `seg` = 7-seg code of the selected digit, using the standard table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any non-BCD value shows 0011111.
- Expiry blink: while `done`=1, `seg` is forced to 0000000 during alternate half-second windows of a free-running SEC_HZ-based phase.

## Timing
- Reset values: `de`=0, `seg`=1111110, `done`=0, `wrap`=0, all digits 0, all prescalers 0.
- Count latency: digits update on the `mclk` edge on which the tick enable is high.
- `seg` lags `de` and the digits by exactly one `mclk` cycle.
- First tick after `load` or `enable`↑ occurs a full period later, not a partial one.
- Simultaneous `load` and `rst`: `rst` wins.

## Structure
- Shared package `timer_pkg`:
  - 7-seg code constants and the blank/error codes.
  - Digit-index constants 0..5.
  - Run-state enum {RUN, HOLD, EXPIRED}.
- Sub-module `rate_tick`:
  - Parameter DIV.
  - Inputs `clr`, `en`; output is a one-cycle `tick`.
  - Instantiated for the count-rate and scan prescalers.
- The debounce stage stays outside this block.

## Test plan
Use CLK_HZ=100, SEC_HZ=1, FAST_HZ=10, SCAN_HZ=50 for simulation.
- Reset then `enable`=1, `dir`=0, `speed`=1: after 10 cycles s0=1; after 600 cycles the display reads 00:01:00.
- Up wrap, HOURS=12: load 11:59:59, then one tick gives 00:00:00 and `wrap` is high for exactly one cycle. Repeat with HOURS=24: load 23:59:59, and the tick wraps to 00:00:00.
- Down mode: load 00:00:02, run; after 2 ticks the count is 00:00:00 and `done`=1. A further 30 ticks leave it unchanged, and `seg` blanks on alternate windows.
- Invalid preset 13:75:0A with HOURS=12: load gives 00:00:00. Preset 10:30:45 loads exactly.
- `load` on the same cycle as a tick gives the preset value, with no increment applied. Toggling `speed` mid-period restarts the prescaler, and the next tick arrives a full period later.
- `rst` asserted asynchronously mid-count: digits, `de`, `seg`=1111110 and `done` clear before the next `mclk` edge. `de` then sequences 0..5 every 2 cycles, with `seg` matching the digit one cycle later.
